writeback: RTL and testbench
============================

Name: writeback

Overview:
- Final pipeline stage, directly downstream of the memory stage.
- Consumes the memory stage's pipeline outputs (result, rd, opcode, exception, halt) and retires instructions.
- Drives the register-file write port and a forwarding bus; converts exceptions into a trap request with a handshake to the control unit.
- Stops the core on halt.

Parameters:
- DATA_W, 32, register data width (`REG_DATA_SIZE`+1).
- RADDR_W, 5, register address width (`REG_ADDR_SIZE`+1).
- EX_W, 4, exception cause width (`EX_WIDTH`+1).

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- pipeline_in_valid  in  1  memory stage output valid.
- opcode_in  in  5  instr[6:2].
- nop_instr_in  in  1  bubble/NOP marker.
- result_in  in  DATA_W  value to write back.
- rd_addr_in  in  RADDR_W  destination register.
- exception_in  in  EX_W  cause code.
- exception_in_valid  in  1  exception present.
- halt_in  in  1  halt instruction retiring.
- trap_ack  in  1  control unit accepted trap.
- rf_wr_en  out  1  register-file write enable.
- rf_wr_addr  out  RADDR_W  write address.
- rf_wr_data  out  DATA_W  write data.
- fwd_valid  out  1  forwarding entry valid (same cycle as rf_wr_en).
- fwd_addr  out  RADDR_W  forwarded register.
- fwd_data  out  DATA_W  forwarded value.
- trap_valid  out  1  trap request pending.
- trap_cause  out  EX_W  latched cause.
- flush_out  out  1  one-cycle pulse to flush upstream stages.
- stall_out  out  1  stall to memory stage.
- halted  out  1  core halted (sticky).

Behaviour:
- Reset (reset==0, async): all outputs 0, FSM=RUN.
- Write-enable predicate: accept = pipeline_in_valid && !stall_out in RUN. An accepted instruction writes when !nop_instr_in && !exception_in_valid && rd_addr_in!=0 && opcode_in not in {`OP_STORE`, `OP_BRANCH`, `OP_MISC_MEM`}.
- Write latency: exactly 1 cycle. Register rf_wr_en/addr/data on accept; fwd_* mirror rf_wr_* exactly. rf_wr_en deasserts the next cycle unless another write is accepted.
- rd==0: never written, regardless of opcode.
- FSM RUN:
  - Accepted with exception_in_valid -> TRAP. Latch trap_cause=exception_in, trap_valid=1, flush_out=1 for one cycle. No rf write.
  - Accepted with halt_in (no exception) -> HALTED. Performs its own rf write if eligible; halted=1 next cycle.
  - Exception and halt together -> exception wins (TRAP).
- FSM TRAP:
  - stall_out=1 combinationally; trap_valid held and trap_cause stable until trap_ack.
  - trap_ack sampled high -> trap_valid=0, back to RUN next cycle.
  - trap_ack while not in TRAP is ignored.
- FSM HALTED:
  - Terminal until reset. stall_out=1, halted=1, rf_wr_en=0.
  - Incoming valid instructions are ignored.
- stall_out is 0 in RUN; this block never back-pressures in RUN.
- Reset mid-TRAP or mid-HALTED: immediate return to RUN with all outputs 0, including dropping a pending trap_valid.

Optional Feature:
- Macro WB_INSTRET_EN.
- When defined:
  - Adds output instret (64 bits); reset value 0.
  - Increments by 1 on each accepted valid instruction with !nop_instr_in && !exception_in_valid, including the halt instruction.
  - Wraps modulo 2^64.
- When undefined: port and counter absent; the rest of the behaviour is identical.

Decomposition:
- Shared def_params include: `OP_*` opcode defines, `REG_DATA_SIZE`, `REG_ADDR_SIZE`, `EX_WIDTH`, FSM state encodings (WB_RUN=2'd0, WB_TRAP=2'd1, WB_HALTED=2'd2).
- One natural sub-module: wb_retire_counter, the 64-bit instret counter, instantiated only under WB_INSTRET_EN.

Test Plan:
- Reset low mid-stream -> all outputs 0 immediately (async); after release, first valid instruction accepted.
- Valid ALU op rd=5 result=0xDEADBEEF -> next cycle rf_wr_en=1, rf_wr_addr=5, rf_wr_data=0xDEADBEEF, fwd_* equal; following cycle rf_wr_en=0.
- Valid op with rd=0, a STORE rd=7, and a NOP in consecutive cycles -> rf_wr_en stays 0 throughout; with WB_INSTRET_EN, instret advances by 2 (ALU rd=0 and STORE; not the NOP).
- Valid op with exception_in_valid=1 and cause=4'd2 -> trap_valid=1, trap_cause=2, flush_out pulses one cycle, stall_out=1. Hold trap_ack=0 for 3 cycles, then 1 -> trap_valid falls the cycle after, stall_out=0, next instruction retires.
- Valid op with halt_in=1 rd=3 result=0x10 -> r3 written, halted=1 and stall_out=1 persist; further valid inputs produce no writes until reset.
- exception_in_valid and halt_in asserted together -> TRAP entered, halted stays 0.

Source files
------------

// File: rtl/writeback_pkg.sv
// Shared definitions for the writeback stage: field widths, opcodes (instr[6:2]) and FSM states.
package writeback_pkg;

    localparam int unsigned REG_DATA_SIZE = 31;
    localparam int unsigned REG_ADDR_SIZE = 4;
    localparam int unsigned EX_WIDTH      = 3;

    localparam logic [4:0] OP_LOAD     = 5'b00000;
    localparam logic [4:0] OP_MISC_MEM = 5'b00011;
    localparam logic [4:0] OP_OP_IMM   = 5'b00100;
    localparam logic [4:0] OP_STORE    = 5'b01000;
    localparam logic [4:0] OP_OP       = 5'b01100;
    localparam logic [4:0] OP_BRANCH   = 5'b11000;
    localparam logic [4:0] OP_JAL      = 5'b11011;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StTrap   = 2'd1,
        StHalted = 2'd2
    } wb_state_e;

    // Stores, branches and fences carry no destination register.
    function automatic logic op_writes_rd(input logic [4:0] op);
        return !((op == OP_STORE) || (op == OP_BRANCH) || (op == OP_MISC_MEM));
    endfunction

endpackage

// File: rtl/wb_retire_counter.sv
// 64-bit retired-instruction counter, wraps modulo 2^64.
module wb_retire_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    output logic [63:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 64'd0;
        end else if (inc) begin
            count <= count + 64'd1;
        end
    end

endmodule

// File: rtl/writeback.sv
// Writeback stage: retires instructions, drives the register-file write port, forwarding bus,
// trap handshake and halt. Define WB_INSTRET_EN to add the 64-bit instret output.
module writeback
    import writeback_pkg::*;
#(
    parameter int unsigned DATA_W  = REG_DATA_SIZE + 1,
    parameter int unsigned RADDR_W = REG_ADDR_SIZE + 1,
    parameter int unsigned EX_W    = EX_WIDTH + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pipeline_in_valid,
    input  logic [4:0]         opcode_in,
    input  logic               nop_instr_in,
    input  logic [DATA_W-1:0]  result_in,
    input  logic [RADDR_W-1:0] rd_addr_in,
    input  logic [EX_W-1:0]    exception_in,
    input  logic               exception_in_valid,
    input  logic               halt_in,
    input  logic               trap_ack,
    output logic               rf_wr_en,
    output logic [RADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0]  rf_wr_data,
    output logic               fwd_valid,
    output logic [RADDR_W-1:0] fwd_addr,
    output logic [DATA_W-1:0]  fwd_data,
    output logic               trap_valid,
    output logic [EX_W-1:0]    trap_cause,
    output logic               flush_out,
    output logic               stall_out,
    output logic               halted
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0]        instret
`endif
);

    wb_state_e state_q;
    logic      wr_eligible;

    always_comb begin
        wr_eligible = !nop_instr_in && !exception_in_valid && (rd_addr_in != '0)
                      && op_writes_rd(opcode_in);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StRun;
            rf_wr_en   <= 1'b0;
            rf_wr_addr <= '0;
            rf_wr_data <= '0;
            trap_valid <= 1'b0;
            trap_cause <= '0;
            flush_out  <= 1'b0;
        end else begin
            rf_wr_en  <= 1'b0;
            flush_out <= 1'b0;
            unique case (state_q)
                StRun: begin
                    if (pipeline_in_valid) begin
                        // Exception takes priority over a simultaneous halt.
                        if (exception_in_valid) begin
                            state_q    <= StTrap;
                            trap_valid <= 1'b1;
                            trap_cause <= exception_in;
                            flush_out  <= 1'b1;
                        end else begin
                            if (wr_eligible) begin
                                rf_wr_en   <= 1'b1;
                                rf_wr_addr <= rd_addr_in;
                                rf_wr_data <= result_in;
                            end
                            if (halt_in) begin
                                state_q <= StHalted;
                            end
                        end
                    end
                end
                StTrap: begin
                    if (trap_ack) begin
                        trap_valid <= 1'b0;
                        state_q    <= StRun;
                    end
                end
                StHalted: begin
                    state_q <= StHalted;
                end
                default: begin
                    state_q <= StRun;
                end
            endcase
        end
    end

    assign stall_out = (state_q != StRun);
    assign halted    = (state_q == StHalted);
    assign fwd_valid = rf_wr_en;
    assign fwd_addr  = rf_wr_addr;
    assign fwd_data  = rf_wr_data;

`ifdef WB_INSTRET_EN
    logic retire_inc;

    assign retire_inc = pipeline_in_valid && (state_q == StRun) && !nop_instr_in
                        && !exception_in_valid;

    wb_retire_counter u_retire_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (retire_inc),
        .count (instret)
    );
`endif

endmodule

// File: tb/tb_writeback.sv
// Directed testbench for writeback: vector table for single-cycle retires, hand sequences for
// trap, halt and asynchronous reset.
module tb_writeback;

    localparam logic [4:0] T_LOAD     = 5'b00000;
    localparam logic [4:0] T_MISC_MEM = 5'b00011;
    localparam logic [4:0] T_OP_IMM   = 5'b00100;
    localparam logic [4:0] T_STORE    = 5'b01000;
    localparam logic [4:0] T_OP       = 5'b01100;
    localparam logic [4:0] T_BRANCH   = 5'b11000;
    localparam logic [4:0] T_JAL      = 5'b11011;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipeline_in_valid;
    logic [4:0]  opcode_in;
    logic        nop_instr_in;
    logic [31:0] result_in;
    logic [4:0]  rd_addr_in;
    logic [3:0]  exception_in;
    logic        exception_in_valid;
    logic        halt_in;
    logic        trap_ack;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
    logic        trap_valid;
    logic [3:0]  trap_cause;
    logic        flush_out;
    logic        stall_out;
    logic        halted;
`ifdef WB_INSTRET_EN
    logic [63:0] instret;
`endif

    int checks = 0;
    int errors = 0;
    longint unsigned exp_ret = 0;

    writeback dut (
        .clk                (clk),
        .reset              (reset),
        .pipeline_in_valid  (pipeline_in_valid),
        .opcode_in          (opcode_in),
        .nop_instr_in       (nop_instr_in),
        .result_in          (result_in),
        .rd_addr_in         (rd_addr_in),
        .exception_in       (exception_in),
        .exception_in_valid (exception_in_valid),
        .halt_in            (halt_in),
        .trap_ack           (trap_ack),
        .rf_wr_en           (rf_wr_en),
        .rf_wr_addr         (rf_wr_addr),
        .rf_wr_data         (rf_wr_data),
        .fwd_valid          (fwd_valid),
        .fwd_addr           (fwd_addr),
        .fwd_data           (fwd_data),
        .trap_valid         (trap_valid),
        .trap_cause         (trap_cause),
        .flush_out          (flush_out),
        .stall_out          (stall_out),
        .halted             (halted)
`ifdef WB_INSTRET_EN
        ,
        .instret            (instret)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [4:0]  op;
        logic        nop;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        exp_en;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic nop,
                         input logic [4:0] rd, input logic [31:0] res, input logic ev,
                         input logic [3:0] ex, input logic h);
        pipeline_in_valid  = v;
        opcode_in          = op;
        nop_instr_in       = nop;
        rd_addr_in         = rd;
        result_in          = res;
        exception_in_valid = ev;
        exception_in       = ex;
        halt_in            = h;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " rf_wr_en"}, 64'(rf_wr_en), 64'd0);
        chk({tag, " fwd_valid"}, 64'(fwd_valid), 64'd0);
        chk({tag, " trap_valid"}, 64'(trap_valid), 64'd0);
        chk({tag, " flush_out"}, 64'(flush_out), 64'd0);
        chk({tag, " stall_out"}, 64'(stall_out), 64'd0);
        chk({tag, " halted"}, 64'(halted), 64'd0);
`ifdef WB_INSTRET_EN
        chk({tag, " instret"}, instret, 64'd0);
`endif
    endtask

    task automatic chk_write(input string tag, input logic [4:0] rd, input logic [31:0] d);
        chk({tag, " rf_wr_en"}, 64'(rf_wr_en), 64'd1);
        chk({tag, " rf_wr_addr"}, 64'(rf_wr_addr), 64'(rd));
        chk({tag, " rf_wr_data"}, 64'(rf_wr_data), 64'(d));
        chk({tag, " fwd_valid"}, 64'(fwd_valid), 64'd1);
        chk({tag, " fwd_addr"}, 64'(fwd_addr), 64'(rd));
        chk({tag, " fwd_data"}, 64'(fwd_data), 64'(d));
    endtask

    task automatic chk_ret(input string tag);
`ifdef WB_INSTRET_EN
        chk({tag, " instret"}, instret, exp_ret);
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    initial begin
        reset    = 1'b0;
        trap_ack = 1'b0;
        drive(1'b0, T_OP, 1'b0, 5'd0, 32'd0, 1'b0, 4'd0, 1'b0);

        vecs[0] = '{1'b1, T_OP,       1'b0, 5'd5,  32'hDEADBEEF, 1'b1};
        vecs[1] = '{1'b1, T_OP,       1'b0, 5'd0,  32'h11111111, 1'b0};
        vecs[2] = '{1'b1, T_STORE,    1'b0, 5'd7,  32'h22222222, 1'b0};
        vecs[3] = '{1'b1, T_OP,       1'b1, 5'd8,  32'h33333333, 1'b0};
        vecs[4] = '{1'b1, T_OP_IMM,   1'b0, 5'd31, 32'h0000ABCD, 1'b1};
        vecs[5] = '{1'b1, T_BRANCH,   1'b0, 5'd9,  32'h44444444, 1'b0};
        vecs[6] = '{1'b1, T_MISC_MEM, 1'b0, 5'd10, 32'h55555555, 1'b0};
        vecs[7] = '{1'b1, T_LOAD,     1'b0, 5'd1,  32'hCAFEF00D, 1'b1};
        vecs[8] = '{1'b0, T_OP,       1'b0, 5'd12, 32'h66666666, 1'b0};
        vecs[9] = '{1'b1, T_JAL,      1'b0, 5'd2,  32'h00001004, 1'b1};

        #12;
        chk_idle("reset");
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].valid, vecs[i].op, vecs[i].nop, vecs[i].rd, vecs[i].res,
                  1'b0, 4'd0, 1'b0);
            if (vecs[i].valid && !vecs[i].nop) exp_ret++;
            tick();
            if (vecs[i].exp_en) begin
                chk_write($sformatf("vec%0d", i), vecs[i].rd, vecs[i].res);
            end else begin
                chk($sformatf("vec%0d rf_wr_en", i), 64'(rf_wr_en), 64'd0);
                chk($sformatf("vec%0d fwd_valid", i), 64'(fwd_valid), 64'd0);
            end
            chk_ret($sformatf("vec%0d", i));
        end
        drive(1'b0, T_OP, 1'b0, 5'd0, 32'd0, 1'b0, 4'd0, 1'b0);
        tick();
        chk("after table rf_wr_en", 64'(rf_wr_en), 64'd0);

        // Trap: cause 2, hold ack low for 3 cycles while upstream keeps presenting work.
        drive(1'b1, T_OP, 1'b0, 5'd9, 32'h99, 1'b1, 4'd2, 1'b0);
        tick();
        chk("trap entry trap_valid", 64'(trap_valid), 64'd1);
        chk("trap entry trap_cause", 64'(trap_cause), 64'd2);
        chk("trap entry flush_out", 64'(flush_out), 64'd1);
        chk("trap entry stall_out", 64'(stall_out), 64'd1);
        chk("trap entry rf_wr_en", 64'(rf_wr_en), 64'd0);
        chk_ret("trap entry");
        drive(1'b1, T_OP, 1'b0, 5'd11, 32'h77, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("trap hold%0d trap_valid", i), 64'(trap_valid), 64'd1);
            chk($sformatf("trap hold%0d trap_cause", i), 64'(trap_cause), 64'd2);
            chk($sformatf("trap hold%0d flush_out", i), 64'(flush_out), 64'd0);
            chk($sformatf("trap hold%0d stall_out", i), 64'(stall_out), 64'd1);
            chk($sformatf("trap hold%0d rf_wr_en", i), 64'(rf_wr_en), 64'd0);
        end
        trap_ack = 1'b1;
        tick();
        chk("trap ack trap_valid", 64'(trap_valid), 64'd0);
        chk("trap ack stall_out", 64'(stall_out), 64'd0);
        chk("trap ack rf_wr_en", 64'(rf_wr_en), 64'd0);
        chk_ret("trap ack");
        trap_ack = 1'b1;
        drive(1'b1, T_OP, 1'b0, 5'd6, 32'h55, 1'b0, 4'd0, 1'b0);
        exp_ret++;
        tick();
        chk_write("post trap", 5'd6, 32'h55);
        chk("stray ack trap_valid", 64'(trap_valid), 64'd0);
        chk_ret("post trap");
        trap_ack = 1'b0;

        // Exception together with halt: trap wins, no halt.
        drive(1'b1, T_OP, 1'b0, 5'd4, 32'h1, 1'b1, 4'hA, 1'b1);
        tick();
        chk("exc+halt trap_valid", 64'(trap_valid), 64'd1);
        chk("exc+halt trap_cause", 64'(trap_cause), 64'hA);
        chk("exc+halt halted", 64'(halted), 64'd0);
        chk("exc+halt rf_wr_en", 64'(rf_wr_en), 64'd0);
        drive(1'b0, T_OP, 1'b0, 5'd0, 32'd0, 1'b0, 4'd0, 1'b0);
        trap_ack = 1'b1;
        tick();
        trap_ack = 1'b0;
        chk("exc+halt release halted", 64'(halted), 64'd0);
        chk("exc+halt release stall_out", 64'(stall_out), 64'd0);

        // Halt writes its own result, then ignores everything.
        drive(1'b1, T_OP, 1'b0, 5'd3, 32'h10, 1'b0, 4'd0, 1'b1);
        exp_ret++;
        tick();
        chk_write("halt", 5'd3, 32'h10);
        chk("halt halted", 64'(halted), 64'd1);
        chk("halt stall_out", 64'(stall_out), 64'd1);
        chk_ret("halt");
        drive(1'b1, T_OP, 1'b0, 5'd4, 32'h20, 1'b0, 4'd0, 1'b0);
        trap_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("halted%0d rf_wr_en", i), 64'(rf_wr_en), 64'd0);
            chk($sformatf("halted%0d halted", i), 64'(halted), 64'd1);
            chk($sformatf("halted%0d stall_out", i), 64'(stall_out), 64'd1);
            chk($sformatf("halted%0d trap_valid", i), 64'(trap_valid), 64'd0);
            chk_ret($sformatf("halted%0d", i));
        end
        trap_ack = 1'b0;

        // Asynchronous reset mid-HALTED, away from any clock edge.
        #2;
        reset = 1'b0;
        #1;
        chk_idle("reset halted");
        exp_ret = 0;
        @(negedge clk);
        reset = 1'b1;

        // Enter trap again, then reset mid-TRAP.
        drive(1'b1, T_OP, 1'b0, 5'd5, 32'h5, 1'b1, 4'd7, 1'b0);
        tick();
        chk("trap2 trap_valid", 64'(trap_valid), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk_idle("reset trap");
        chk("reset trap trap_cause", 64'(trap_cause), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, T_OP_IMM, 1'b0, 5'd13, 32'h12345678, 1'b0, 4'd0, 1'b0);
        exp_ret++;
        tick();
        chk_write("after reset", 5'd13, 32'h12345678);
        chk_ret("after reset");
        drive(1'b0, T_OP, 1'b0, 5'd0, 32'd0, 1'b0, 4'd0, 1'b0);
        tick();
        chk("final rf_wr_en", 64'(rf_wr_en), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
